// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the IF-stage fetch sequencer.
//   fetch_state_t      : sequencer FSM states
//   DEFAULT_RESET_VEC  : PC loaded on reset
//   DEFAULT_TRAP_VEC   : PC loaded on a trap
//   DEFAULT_NOP_INSTR  : instruction shown when nothing is valid (addi x0,x0,0)
//   word_align()       : clears the two low address bits of a redirect target
package fetch_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_BOOT    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_PRESENT = 3'd3,
        ST_HOLD    = 3'd4
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VEC  = 32'h0000_0100;
    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_STEP           = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory fetch port: single outstanding request, req/gnt handshake
// for the address phase and rvalid for the response phase.
//   req    : fetch request (master -> slave)
//   addr   : fetch address (master -> slave)
//   gnt    : request accepted this cycle (slave -> master)
//   rvalid : response data valid (slave -> master)
//   rdata  : response instruction (slave -> master)
interface fetch_sequencer_if;

    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );

endinterface

// File: rtl/fetch_sequencer_pc_redirect_arb.sv
// Combinational next-PC redirect arbiter.
// Priority: trap > EX redirect > ID jump (the ID jump only counts when the
// pipeline is not stalled). The selected target is word aligned.
//   stall_i        : hazard unit stall, masks the ID jump
//   trap_i         : trap request, target TRAP_VEC
//   ex_redirect_i  : EX branch redirect, target ex_target_i
//   id_jump_i      : ID jump, target id_target_i
//   redirect_o     : a redirect is taken this cycle
//   target_o       : aligned redirect target (0 when no redirect)
module fetch_sequencer_pc_redirect_arb
    import fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] TRAP_VEC = DEFAULT_TRAP_VEC
) (
    input  logic        stall_i,
    input  logic        trap_i,
    input  logic        ex_redirect_i,
    input  logic [31:0] ex_target_i,
    input  logic        id_jump_i,
    input  logic [31:0] id_target_i,
    output logic        redirect_o,
    output logic [31:0] target_o
);

    // Fixed-priority select; an ID jump during a stall belongs to an
    // instruction that has not really left ID yet, so it is dropped.
    always_comb begin
        redirect_o = 1'b0;
        target_o   = '0;
        if (trap_i) begin
            redirect_o = 1'b1;
            target_o   = word_align(TRAP_VEC);
        end else if (ex_redirect_i) begin
            redirect_o = 1'b1;
            target_o   = word_align(ex_target_i);
        end else if (id_jump_i && !stall_i) begin
            redirect_o = 1'b1;
            target_o   = word_align(id_target_i);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// IF-stage fetch sequencer: owns the PC, issues one fetch at a time on the
// imem port, squashes fetches overtaken by a redirect, and presents one
// fetched instruction at a time to the IF/ID register.
//   clk, rst_n     : clock, asynchronous active-low reset
//   stall_i        : IF/ID must hold its contents
//   trap_i         : redirect to TRAP_VEC (highest priority)
//   ex_redirect_i  : EX redirect to ex_target_i
//   id_jump_i      : ID jump to id_target_i (ignored while stalled)
//   imem           : fetch port (master side)
//   pc_o           : PC of the next fetch to issue
//   if_valid_o     : if_pc_o / if_instr_o valid
//   if_pc_o        : PC of the presented instruction
//   if_instr_o     : presented instruction, NOP_INSTR when nothing valid
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = DEFAULT_RESET_VEC,
    parameter logic [31:0] TRAP_VEC  = DEFAULT_TRAP_VEC,
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     stall_i,
    input  logic                     trap_i,
    input  logic                     ex_redirect_i,
    input  logic [31:0]              ex_target_i,
    input  logic                     id_jump_i,
    input  logic [31:0]              id_target_i,
    fetch_sequencer_if.master        imem,
    output logic [31:0]              pc_o,
    output logic                     if_valid_o,
    output logic [31:0]              if_pc_o,
    output logic [31:0]              if_instr_o
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic         kill_q, kill_d;
    logic         valid_q, valid_d;
    logic [31:0]  if_pc_q, if_pc_d;
    logic [31:0]  if_instr_q, if_instr_d;
    logic         redirect;
    logic [31:0]  target;
    logic         req;

    fetch_sequencer_pc_redirect_arb #(
        .TRAP_VEC (TRAP_VEC)
    ) u_arb (
        .stall_i       (stall_i),
        .trap_i        (trap_i),
        .ex_redirect_i (ex_redirect_i),
        .ex_target_i   (ex_target_i),
        .id_jump_i     (id_jump_i),
        .id_target_i   (id_target_i),
        .redirect_o    (redirect),
        .target_o      (target)
    );

    // State and datapath registers; everything clears as soon as rst_n drops
    // so a fetch in flight at reset is simply forgotten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_VEC;
            fetch_pc_q <= '0;
            kill_q     <= 1'b0;
            valid_q    <= 1'b0;
            if_pc_q    <= '0;
            if_instr_q <= NOP_INSTR;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fetch_pc_q <= fetch_pc_d;
            kill_q     <= kill_d;
            valid_q    <= valid_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
        end
    end

    // Next-state logic. A redirect always reloads the PC whatever the state;
    // what differs is how the fetch in flight or the buffered instruction is
    // dropped. kill marks a granted fetch whose response must be discarded.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fetch_pc_d = fetch_pc_q;
        kill_d     = kill_q;
        valid_d    = valid_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        req        = 1'b0;

        case (state_q)
            ST_BOOT: begin
                if (redirect) begin
                    pc_d = target;
                end
                state_d = ST_ISSUE;
            end

            ST_ISSUE: begin
                req = 1'b1;
                if (imem.gnt) begin
                    fetch_pc_d = pc_q;
                    state_d    = ST_WAIT;
                    if (redirect) begin
                        pc_d   = target;
                        kill_d = 1'b1;
                    end else begin
                        pc_d = pc_q + PC_STEP;
                    end
                end else if (redirect) begin
                    pc_d = target;
                end
            end

            ST_WAIT: begin
                if (imem.rvalid) begin
                    kill_d = 1'b0;
                    if (redirect) begin
                        pc_d    = target;
                        state_d = ST_ISSUE;
                    end else if (kill_q) begin
                        state_d = ST_ISSUE;
                    end else begin
                        valid_d    = 1'b1;
                        if_pc_d    = fetch_pc_q;
                        if_instr_d = imem.rdata;
                        state_d    = stall_i ? ST_HOLD : ST_PRESENT;
                    end
                end else if (redirect) begin
                    pc_d   = target;
                    kill_d = 1'b1;
                end
            end

            ST_PRESENT: begin
                if (redirect) begin
                    valid_d = 1'b0;
                    pc_d    = target;
                    state_d = ST_ISSUE;
                end else if (stall_i) begin
                    state_d = ST_HOLD;
                end else begin
                    valid_d = 1'b0;
                    state_d = ST_ISSUE;
                end
            end

            ST_HOLD: begin
                if (redirect) begin
                    valid_d = 1'b0;
                    pc_d    = target;
                    state_d = ST_ISSUE;
                end else if (!stall_i) begin
                    valid_d = 1'b0;
                    state_d = ST_ISSUE;
                end
            end

            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // Only one fetch may be outstanding, so the memory must not grant
    // anywhere except while a request is being offered.
    assert property (@(posedge clk) disable iff (!rst_n)
        imem.gnt |-> (state_q == ST_ISSUE));

    assign imem.req   = req;
    assign imem.addr  = pc_q;
    assign pc_o       = pc_q;
    assign if_valid_o = valid_q;
    assign if_pc_o    = if_pc_q;
    assign if_instr_o = valid_q ? if_instr_q : NOP_INSTR;

endmodule
